instr_rom_fetch_arbiter: RTL

Sequences 32-bit word reads out of a single byte-wide, 1-cycle-latency block ROM and shares that ROM port between the instruction-fetch port and a data-read port. Replaces the four parallel byte ROM copies with one ROM and a four-beat read sequence. Assembles bytes big-endian and returns each word with a single-cycle acknowledge. Sits between the core's fetch/load stages and the ROM generated by the block design wrapper.

---
 rtl/instr_rom_fetch_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/instr_rom_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// instr_rom_fetch_arbiter
//
// Shares one byte-wide, 1-cycle-latency block ROM between the instruction
// fetch port (if_*) and the data-read port (dm_*). Each granted request is
// served as four sequential byte reads assembled big-endian into a 32-bit word,
// returned with a single-cycle acknowledge.
//
// Handshake: a requester raises *_req with a stable *_addr and keeps it high
// until *_ack. The address is latched at grant, so later changes to *_addr or
// an early drop of *_req do not disturb a transaction already in flight. The
// ack is a one-cycle pulse and *_rdata is valid in that cycle and is held
// until that port's next ack. A req still high in the cycle after its ack is
// treated as a new request.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   if_req/if_addr      fetch request and byte address
//   if_ack/if_rdata     fetch acknowledge pulse and returned word
//   dm_req/dm_addr      data-read request and byte address
//   dm_ack/dm_rdata     data-read acknowledge pulse and returned word
//   rom_en/rom_a        registered ROM read enable and byte address
//   rom_d               ROM read data, valid one cycle after rom_en/rom_a
//   busy                high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module instr_rom_fetch_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic [31:0]       dm_addr,
  output logic              dm_ack,
  output logic [31:0]       dm_rdata,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [7:0]        rom_d,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                owner_dm_q, owner_dm_d;      // 1: current owner is dm
  logic                last_dm_q, last_dm_d;        // 1: dm was granted last
  logic [31:0]         asm_q, asm_d;
  logic                rom_en_q, rom_en_d;
  logic [ADDR_W-1:0]   rom_a_q, rom_a_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         dm_rdata_q, dm_rdata_d;

  logic                grant_dm;
  logic [ADDR_W-1:0]   grant_addr;
  logic [31:0]         full_word;

  // Upper address bits are intentionally ignored; the ROM wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};

  // Round-robin: on a tie the port that did not win last time is granted.
  assign grant_dm   = dm_req && (!if_req || !last_dm_q);
  assign grant_addr = grant_dm ? dm_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];

  // Byte 3 arrives on rom_d during LAST, so the word handed to the owner is
  // formed from the three captured bytes plus the live ROM byte.
  assign full_word = {asm_q[31:8], rom_d};

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    base_d     = base_q;
    owner_dm_d = owner_dm_q;
    last_dm_d  = last_dm_q;
    asm_d      = asm_q;
    rom_en_d   = rom_en_q;
    rom_a_d    = rom_a_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          owner_dm_d = grant_dm;
          last_dm_d  = grant_dm;
          base_d     = grant_addr;
          // Present beat 0 so the ROM sees it in the first READ cycle.
          rom_en_d   = 1'b1;
          rom_a_d    = grant_addr;
          k_d        = 2'd0;
          state_d    = READ;
        end
      end

      READ: begin
        // rom_d now carries the byte requested by beat k-1.
        case (k_q)
          2'd1:    asm_d[31:24] = rom_d;
          2'd2:    asm_d[23:16] = rom_d;
          2'd3:    asm_d[15:8]  = rom_d;
          default: asm_d        = asm_q;
        endcase
        if (k_q == 2'd3) begin
          rom_en_d = 1'b0;
          k_d      = 2'd0;
          state_d  = LAST;
        end else begin
          k_d     = k_q + 2'd1;
          rom_a_d = base_q + ADDR_W'(k_q + 2'd1);
        end
      end

      LAST: begin
        asm_d[7:0] = rom_d;
        if (owner_dm_q) begin
          dm_ack_d   = 1'b1;
          dm_rdata_d = full_word;
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = full_word;
        end
        state_d = ACK;
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      base_q     <= '0;
      owner_dm_q <= 1'b0;
      last_dm_q  <= 1'b1;
      asm_q      <= 32'd0;
      rom_en_q   <= 1'b0;
      rom_a_q    <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      base_q     <= base_d;
      owner_dm_q <= owner_dm_d;
      last_dm_q  <= last_dm_d;
      asm_q      <= asm_d;
      rom_en_q   <= rom_en_d;
      rom_a_q    <= rom_a_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_ack   = if_ack_q;
  assign dm_ack   = dm_ack_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign rom_en   = rom_en_q;
  assign rom_a    = rom_a_q;
  assign busy     = (state_q != IDLE);

endmodule
